// File: rtl/mem_ctrl_arbiter.sv
// Byte-serial RAM controller and arbiter shared by the instruction fetcher and the LSB.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSB-first priority.
module mem_ctrl_arbiter #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_ADDR = 32'h30000
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              _clear,
   input  logic              _if_req,
   input  logic [ADDR_W-1:0] _if_addr,
   output logic              _if_done,
   output logic [31:0]       _if_data,
   input  logic              _ls_req,
   input  logic              _ls_wr,
   input  logic [1:0]        _ls_size,
   input  logic              _ls_signed,
   input  logic [ADDR_W-1:0] _ls_addr,
   input  logic [31:0]       _ls_wdata,
   output logic              _ls_done,
   output logic [31:0]       _ls_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_LS   = 2'd2;

   logic [1:0]        state, owner;
   logic [ADDR_W-1:0] addr, last_a, cur_a;
   logic [31:0]       wdata, buffer, ext;
   logic [2:0]        beat, n_beats, ls_n;
   logic [1:0]        lane;
   logic [7:0]        last_dout, cur_dout;
   logic              sgn, is_wr, active, bus_st, io_block;
   logic              grant_ls, grant_if;

`ifdef MEM_ARB_RR_EN
   logic last_ls;
   assign grant_ls = _ls_req && (!_if_req || !last_ls);
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in)
         last_ls <= 1'b0;
      else if (rdy_in && state == S_IDLE && !_clear && (_ls_req || _if_req))
         last_ls <= grant_ls;
`else
   assign grant_ls = _ls_req;
`endif
   assign grant_if = _if_req && !grant_ls;

   assign ls_n     = (_ls_size == 2'd0) ? 3'd1 : (_ls_size == 2'd1) ? 3'd2 : 3'd4;
   assign active   = (state == S_READ && beat < n_beats) || state == S_WRITE;
   assign bus_st   = state == S_READ || state == S_WRITE;
   assign cur_a    = active ? addr + {{(ADDR_W-3){1'b0}}, beat} : '0;
   assign cur_dout = (state == S_WRITE) ? wdata[{beat[1:0], 3'b000} +: 8] : 8'h00;
   assign io_block = state == S_WRITE && beat == 3'd0 && addr == IO_ADDR && io_buffer_full;
   assign lane     = 2'(beat - 3'd1);

   // While paused, replay the previous active beat so mem_din on resume matches it.
   assign mem_a    = rdy_in ? cur_a : (bus_st ? last_a : '0);
   assign mem_dout = rdy_in ? cur_dout : ((state == S_WRITE) ? last_dout : 8'h00);
   assign mem_wr   = rdy_in && state == S_WRITE && !io_block;

   assign _if_done = rdy_in && state == S_DONE && owner == OWN_IF && !_clear;
   assign _ls_done = rdy_in && state == S_DONE && owner == OWN_LS && !(_clear && !is_wr);
   assign _if_data = _if_done ? buffer : 32'h0;
   assign _ls_rdata = _ls_done ? ext : 32'h0;

   always_comb begin
      ext = buffer;
      case (n_beats)
         3'd1:    ext[31:8]  = {24{sgn & buffer[7]}};
         3'd2:    ext[31:16] = {16{sgn & buffer[15]}};
         default: ext = buffer;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= S_IDLE;
         owner     <= OWN_NONE;
         addr      <= '0;
         last_a    <= '0;
         last_dout <= 8'h00;
         wdata     <= 32'h0;
         buffer    <= 32'h0;
         beat      <= 3'd0;
         n_beats   <= 3'd0;
         sgn       <= 1'b0;
         is_wr     <= 1'b0;
      end else if (rdy_in) begin
         last_a    <= cur_a;
         last_dout <= cur_dout;
         case (state)
            S_IDLE: if (!_clear && (grant_ls || grant_if)) begin
               beat   <= 3'd0;
               buffer <= 32'h0;
               if (grant_ls) begin
                  owner   <= OWN_LS;
                  addr    <= _ls_addr;
                  wdata   <= _ls_wdata;
                  sgn     <= _ls_signed;
                  is_wr   <= _ls_wr;
                  n_beats <= ls_n;
                  state   <= _ls_wr ? S_WRITE : S_READ;
               end else begin
                  owner   <= OWN_IF;
                  addr    <= _if_addr;
                  wdata   <= 32'h0;
                  sgn     <= 1'b0;
                  is_wr   <= 1'b0;
                  n_beats <= 3'd4;
                  state   <= S_READ;
               end
            end
            S_READ: if (_clear) begin
               state <= S_IDLE;
               owner <= OWN_NONE;
            end else begin
               // mem_din carries the byte for the beat driven one cycle earlier.
               if (beat != 3'd0) buffer[{lane, 3'b000} +: 8] <= mem_din;
               if (beat == n_beats) state <= S_DONE;
               else beat <= beat + 3'd1;
            end
            S_WRITE: if (!io_block) begin
               if (beat == n_beats - 3'd1) state <= S_DONE;
               else beat <= beat + 3'd1;
            end
            default: begin
               state <= S_IDLE;
               owner <= OWN_NONE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Scoreboard bench: drivers push expected responses from a byte-array memory model; a negedge monitor checks done pulses.
module tb_mem_ctrl_arbiter;
   localparam logic [31:0] IO = 32'h30000;

   typedef struct {bit chk; logic [31:0] data;} exp_t;
   typedef struct {logic [31:0] a; logic wr; logic [7:0] d;} bus_t;

   logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, _clear = 1'b0;
   logic        _if_req = 1'b0, _ls_req = 1'b0, _ls_wr = 1'b0, _ls_signed = 1'b0;
   logic [31:0] _if_addr = 32'h0, _ls_addr = 32'h0, _ls_wdata = 32'h0;
   logic [1:0]  _ls_size = 2'd0;
   logic        io_buffer_full = 1'b0;
   logic [7:0]  mem_din = 8'h00;
   logic        _if_done, _ls_done, mem_wr;
   logic [31:0] _if_data, _ls_rdata, mem_a;
   logic [7:0]  mem_dout;

   int vecs = 0, errs = 0, cyc = 0;
   logic [7:0]  ram [65536];
   bit          written [65536];
   logic [7:0]  gold [65536];
   logic [7:0]  io_log [$];
   logic [31:0] q_if [$];
   exp_t        q_ls [$];
   bus_t        if_tr [$], ls_tr [$];
   logic [31:0] ei;
   exp_t        el;
   bit          stop;

   mem_ctrl_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
      ._if_req(_if_req), ._if_addr(_if_addr), ._if_done(_if_done), ._if_data(_if_data),
      ._ls_req(_ls_req), ._ls_wr(_ls_wr), ._ls_size(_ls_size), ._ls_signed(_ls_signed),
      ._ls_addr(_ls_addr), ._ls_wdata(_ls_wdata), ._ls_done(_ls_done), ._ls_rdata(_ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h0100: return 8'h13;
         16'h0101: return 8'h05;
         16'h0102, 16'h0103: return 8'h00;
         16'h0300: return 8'h80;
         16'h0310: return 8'h01;
         16'h0311: return 8'h80;
         default: return 8'(a[7:0] * 8'd29 + a[15:8] * 8'd7 + 8'h5A);
      endcase
   endfunction

   // RAM: registered read one cycle after the address, independent of rdy_in.
   always @(posedge clk_in) begin
      cyc <= cyc + 1;
      mem_din <= written[mem_a[15:0]] ? ram[mem_a[15:0]] : init_byte(mem_a[15:0]);
      if (mem_wr) begin
         if (mem_a == IO) io_log.push_back(mem_dout);
         else begin
            ram[mem_a[15:0]] <= mem_dout;
            written[mem_a[15:0]] <= 1'b1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk_in) if (rst_in) begin
      if (_if_done) begin
         if (q_if.size() == 0) check("if_unexpected_done", 32'd1, 32'd0);
         else begin
            ei = q_if.pop_front();
            check("if_data", _if_data, ei);
         end
      end
      if (_ls_done) begin
         if (q_ls.size() == 0) check("ls_unexpected_done", 32'd1, 32'd0);
         else begin
            el = q_ls.pop_front();
            if (el.chk) check("ls_rdata", _ls_rdata, el.data);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic dir_fetch(input logic [31:0] a, input int lat, input string nm);
      int t0;
      bit seen;
      logic [31:0] v;
      v = 32'h0;
      for (int k = 0; k < 4; k++) v = v | (32'(gold[16'(a + 32'(k))]) << (8 * k));
      q_if.push_back(v);
      if_tr.delete();
      _if_addr = a;
      _if_req = 1'b1;
      t0 = cyc;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk_in); #2;
         if_tr.push_back('{mem_a, mem_wr, mem_dout});
         if (_if_done) seen = 1;
      end
      _if_req = 1'b0;
      if (lat >= 0) check({nm, "_latency"}, 32'(cyc - t0), 32'(lat));
      else if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic dir_ls(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input string nm);
      int t0, n;
      bit seen;
      logic [31:0] v;
      exp_t e;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (wr) begin
         if (a != IO) for (int k = 0; k < n; k++) gold[16'(a + 32'(k))] = wd[8*k +: 8];
         e.chk = 0;
         e.data = 32'h0;
      end else begin
         v = 32'h0;
         for (int k = 0; k < n; k++) v = v | (32'(gold[16'(a + 32'(k))]) << (8 * k));
         if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
         e.chk = 1;
         e.data = v;
      end
      q_ls.push_back(e);
      ls_tr.delete();
      _ls_wr = wr; _ls_size = sz; _ls_signed = sg; _ls_addr = a; _ls_wdata = wd;
      _ls_req = 1'b1;
      t0 = cyc;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk_in); #2;
         ls_tr.push_back('{mem_a, mem_wr, mem_dout});
         if (_ls_done) seen = 1;
      end
      _ls_req = 1'b0;
      if (lat >= 0) check({nm, "_latency"}, 32'(cyc - t0), 32'(lat));
      else if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic rand_round(input int nf, input int nl);
      fork
         for (int i = 0; i < nf; i++) begin
            dir_fetch(32'h400 + 4 * 32'($urandom_range(0, 32'h2FF)), -1, "rnd_fetch");
            idle($urandom_range(0, 2));
         end
         for (int i = 0; i < nl; i++) begin
            dir_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   32'h1000 + 32'($urandom_range(0, 32'hFF0)), $urandom, -1, "rnd_ls");
            idle($urandom_range(0, 2));
         end
      join
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 65536; i++) gold[i] = init_byte(16'(i));
      #12;
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wr", 32'(mem_wr), 32'h0);
      check("rst_mem_dout", 32'(mem_dout), 32'h0);
      check("rst_if_done", 32'(_if_done), 32'h0);
      check("rst_ls_done", 32'(_ls_done), 32'h0);
      check("rst_if_data", _if_data, 32'h0);
      check("rst_ls_rdata", _ls_rdata, 32'h0);
      @(posedge clk_in); #1 rst_in = 1'b1;
      idle(2);

      dir_fetch(32'h100, 6, "fetch100"); idle(1);
      for (int i = 0; i < 4; i++) check("fetch100_addr", if_tr[i].a, 32'h100 + 32'(i));

      dir_ls(1, 2'd2, 0, 32'h200, 32'hDEADBEEF, 5, "st_word"); idle(1);
      for (int i = 0; i < 4; i++) begin
         check("st_word_wr", 32'(ls_tr[i].wr), 32'h1);
         check("st_word_addr", ls_tr[i].a, 32'h200 + 32'(i));
      end
      check("st_word_b0", 32'(ls_tr[0].d), 32'hEF);
      check("st_word_b3", 32'(ls_tr[3].d), 32'hDE);
      dir_ls(0, 2'd2, 0, 32'h200, 0, 6, "ld_word"); idle(1);

      dir_ls(0, 2'd0, 1, 32'h300, 0, 3, "ld_sbyte"); idle(1);
      dir_ls(0, 2'd0, 0, 32'h300, 0, 3, "ld_ubyte"); idle(1);
      dir_ls(0, 2'd1, 1, 32'h310, 0, 4, "ld_shalf"); idle(1);
      dir_ls(0, 2'd1, 0, 32'h310, 0, 4, "ld_uhalf"); idle(1);
      dir_ls(0, 2'd2, 0, 32'hFFFFFFFE, 0, 6, "ld_wrap"); idle(1);
      check("ld_wrap_addr2", ls_tr[2].a, 32'h0);

      // Collision with the LSB re-requesting back to back while fetch waits.
      dir_fetch(32'h100, 6, "pre_col"); idle(1);
      fork
         begin
            dir_ls(0, 2'd2, 0, 32'h1100, 0, 6, "col_ls1");
`ifdef MEM_ARB_RR_EN
            dir_ls(0, 2'd2, 0, 32'h1104, 0, 14, "col_ls2");
`else
            dir_ls(0, 2'd2, 0, 32'h1104, 0, 7, "col_ls2");
`endif
         end
`ifdef MEM_ARB_RR_EN
         dir_fetch(32'h120, 13, "col_fetch");
`else
         dir_fetch(32'h120, 20, "col_fetch");
`endif
      join
      idle(1);

      _if_addr = 32'h140; _if_req = 1'b1;
      idle(3);
      check("clr_beat2_addr", mem_a, 32'h142);
      _clear = 1'b1;
      idle(1);
      _clear = 1'b0; _if_req = 1'b0;
      check("clr_idle_addr", mem_a, 32'h0);
      cnt = 0;
      repeat (8) begin @(posedge clk_in); #1; if (_if_done) cnt++; end
      check("clr_no_done", 32'(cnt), 32'h0);
      _clear = 1'b1; _if_req = 1'b1;
      idle(1);
      _clear = 1'b0; _if_req = 1'b0;
      check("clr_idle_no_grant", mem_a, 32'h0);
      idle(8);

      fork
         dir_ls(1, 2'd2, 0, 32'h1500, 32'h11223344, 5, "clr_store");
         begin idle(2); _clear = 1'b1; idle(1); _clear = 1'b0; end
      join
      idle(1);
      dir_ls(0, 2'd2, 0, 32'h1500, 0, 6, "clr_store_rb"); idle(1);

      io_buffer_full = 1'b1;
      cnt = 0;
      fork
         dir_ls(1, 2'd0, 0, IO, 32'h41, 7, "io_store");
         begin
            repeat (5) begin @(posedge clk_in); #1; if (mem_wr) cnt++; end
            @(posedge clk_in); #1 io_buffer_full = 1'b0;
         end
      join
      idle(1);
      check("io_blocked_writes", 32'(cnt), 32'h0);
      check("io_log_size", 32'(io_log.size()), 32'h1);
      if (io_log.size() > 0) check("io_log_byte", 32'(io_log[0]), 32'h41);

      fork
         dir_fetch(32'h180, 9, "stall_fetch");
         begin idle(2); rdy_in = 1'b0; idle(3); rdy_in = 1'b1; end
      join
      idle(1);
      cnt = 0;
      fork
         dir_ls(1, 2'd2, 0, 32'h1600, 32'hCAFEF00D, 7, "stall_store");
         begin
            idle(2); rdy_in = 1'b0; #1; if (mem_wr) cnt++;
            idle(1); if (mem_wr) cnt++;
            idle(1); rdy_in = 1'b1;
         end
      join
      idle(1);
      check("stall_store_wr", 32'(cnt), 32'h0);
      dir_ls(0, 2'd2, 0, 32'h1600, 0, 6, "stall_store_rb"); idle(1);

      rand_round(15, 25);
      stop = 0;
      fork
         begin rand_round(15, 25); stop = 1; end
         begin
            while (!stop) begin @(posedge clk_in); #1 rdy_in = ($urandom_range(0, 3) != 0); end
            rdy_in = 1'b1;
         end
      join
      idle(5);
      check("if_queue_empty", 32'(q_if.size()), 32'h0);
      check("ls_queue_empty", 32'(q_ls.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
Single-port byte-serial RAM controller and arbiter shared by the instruction fetcher and the load/store buffer.
- Accepts one word-read request from the fetcher and one load or store request from the LSB.
- Grants one request at a time and splits it into byte beats on the 8-bit RAM bus.
- Reassembles and sign/zero-extends load data and returns a one-cycle done pulse to the owner.
- Sits between the LSB/fetcher and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- ADDR_W, 32, address width.
- IO_ADDR, 32'h30000, address whose stores obey io_buffer_full.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  pause when low
- _clear  in  1  pipeline flush (mispredict)
- _if_req  in  1  fetch request; held until _if_done
- _if_addr  in  32  fetch word address
- _if_done  out  1  one-cycle pulse: _if_data valid
- _if_data  out  32  fetched word
- _ls_req  in  1  LSB request; held until _ls_done
- _ls_wr  in  1  1=store, 0=load
- _ls_size  in  2  0=byte, 1=half, 2=word
- _ls_signed  in  1  sign-extend load
- _ls_addr  in  32  byte address
- _ls_wdata  in  32  store data
- _ls_done  out  1  one-cycle pulse
- _ls_rdata  out  32  extended load data
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1=write
- io_buffer_full  in  1  UART buffer full

Behaviour:
Reset (rst_in=0, asynchronous):
- State IDLE; all outputs 0; beat counters 0; owner register = none.

Stall:
- rdy_in=0: all registers hold; mem_wr driven 0.
- On resume, the beat issued in the last active cycle is re-issued (same mem_a, and same mem_dout if writing).

States:
- IDLE:
  - Arbitration: _ls_req beats _if_req (fixed priority).
  - Latch addr, size and wdata of the winner. Beat count n = 1/2/4 for size 0/1/2; fetch always n=4.
  - Go to READ or WRITE.
- READ:
  - Active cycles k=0..n-1 drive mem_a=addr+k, mem_wr=0.
  - RAM returns the byte for the address driven in cycle k on mem_din in cycle k+1; capture it into byte lane k (little-endian).
  - After the cycle that captures lane n-1, go to DONE.
- WRITE:
  - Active cycles k=0..n-1 drive mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - If addr==IO_ADDR and io_buffer_full=1, hold mem_wr=0 and stay at beat 0 until it drops.
  - Then go to DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle.
  - _ls_rdata: lanes above n extended with bit 8n-1 if _ls_signed, else zero.
  - Return to IDLE. A new request is not granted in the DONE cycle.

Latency (accept cycle = T, no stalls):
- Read done pulse at T+n+2 (fetch word = T+6).
- Write done pulse at T+n+1.

Outside WRITE:
- mem_wr=0, mem_dout=0.

_clear (synchronous, rdy_in high):
- Reads: abort; no done pulse; next state IDLE; requests sampled in the same cycle are ignored.
- Writes: continue to completion and still pulse _ls_done, because stores are committed.

Arithmetic:
- Beat address addr+k wraps modulo 2^ADDR_W.

Simultaneous requests:
- Both requests pending in IDLE: LSB granted; fetch waits.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. The requester that was not granted last wins a tie; the last-granted flag resets to "fetch".
- Undefined: fixed LSB-first priority; fetch can starve only while _ls_req remains continuously asserted.

Test Plan:
1. Fetch only, _if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 → mem_a 0x100..0x103 on T+1..T+4; _if_done at T+6 with _if_data=0x00000513.
2. Store word 0xDEADBEEF to 0x200 → mem_wr=1 with mem_dout EF,BE,AD,DE at addrs 0x200..0x203; _ls_done at T+5.
3. Signed byte load of 0x80 from 0x300 → _ls_rdata=0xFFFFFF80. Same load with _ls_signed=0 → 0x00000080.
4. _if_req and _ls_req (load word) raised together → LSB granted first, fetch granted after LSB done. With MEM_ARB_RR_EN, a second collision grants fetch.
5. _clear asserted during a fetch READ beat 2 → no _if_done, IDLE next cycle. _clear during a store beat 1 → all 4 bytes written and _ls_done pulses.
6. Store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles → mem_wr stays 0 for those cycles, then one write. rdy_in low for 3 cycles mid-read → same final data, and done is delayed by exactly 3 cycles.
